fpga_uart_top: RTL and testbench

Top-level FPGA block combining an 8N1 UART transmitter, an 8N1 UART receiver and a 2-bit symbol decoder. Host logic loads a byte on `data_in` and pulses `send`, and the byte is serialized on `tx`. Bytes arriving on `rx` are deserialized and decoded, and the 2-bit symbol is presented on `data_out`, qualified by `valid`. In the board-level loopback configuration `tx` is wired to `rx`.

---
 rtl/fpga_uart_top.sv | 222 ++++++++++++++++++++++
 tb/tb_fpga_uart_top.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_uart_top.sv
// fpga_uart_top: 8N1 UART transmitter and receiver with a 2-bit symbol decoder
// on the receive path. TX and RX run independently; tx may be looped back to rx.
module fpga_uart_top #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       tx,
  output logic [1:0] data_out,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Transmitter state
  uart_state_e      r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;

  // Receiver state
  logic             r_rx_s1, r_rx_s2;
  uart_state_e      r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_byte, w_rx_byte_nxt;
  logic [1:0]       r_data_out, w_data_out_nxt;
  logic             r_valid, w_valid_nxt;

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign data_out = r_data_out;
  assign valid    = r_valid;

  // TX next-state: serialize start, 8 data bits LSB first, stop
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_busy_nxt     = r_busy;
    unique case (r_tx_state)
      ST_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (send) begin
          w_tx_state_nxt = ST_START;
          w_tx_shift_nxt = data_in;
          w_tx_cnt_nxt   = '0;
          w_tx_nxt       = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end
      ST_START: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = 3'd0;
          w_tx_state_nxt = ST_DATA;
          w_tx_nxt       = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = ST_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_nxt       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = ST_IDLE;
          w_busy_nxt     = 1'b0;
          w_tx_nxt       = 1'b1;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_tx_state_nxt = ST_IDLE;
      end
    endcase
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // RX two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // RX next-state: centre-sample the frame, decode legal symbols on a good stop bit
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_byte_nxt  = r_rx_byte;
    w_data_out_nxt = r_data_out;
    w_valid_nxt    = r_valid;
    unique case (r_rx_state)
      ST_IDLE: begin
        if (!r_rx_s2) begin
          w_rx_state_nxt = ST_START;
          w_rx_cnt_nxt   = '0;
          w_valid_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (r_rx_cnt == HALF_END) begin
          w_rx_cnt_nxt = '0;
          if (!r_rx_s2) begin
            w_rx_state_nxt = ST_DATA;
            w_rx_bit_nxt   = 3'd0;
          end else begin
            w_rx_state_nxt = ST_IDLE;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt  = '0;
          w_rx_byte_nxt = {r_rx_s2, r_rx_byte[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = ST_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = ST_IDLE;
          if (r_rx_s2 && (r_rx_byte[7:4] == 4'b0000) && (r_rx_byte[1:0] == 2'b01)) begin
            w_data_out_nxt = r_rx_byte[3:2];
            w_valid_nxt    = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_rx_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RX registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_byte  <= 8'd0;
      r_data_out <= 2'b00;
      r_valid    <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_data_out <= w_data_out_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fpga_uart_top.sv
// Bench for fpga_uart_top: loopback and directly driven rx, with a
// frame-level reference model of the decoder output.
module tb_fpga_uart_top;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx;
  logic       drv_rx = 1'b1;
  logic       loop_en = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       send = 1'b0;
  logic       tx;
  logic [1:0] data_out;
  logic       valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model of the receiver output
  logic       exp_valid = 1'b0;
  logic [1:0] exp_dout  = 2'b00;

  assign rx = loop_en ? tx : drv_rx;

  always #5 clk = ~clk;

  fpga_uart_top #(
    .CLK_FREQ    (1_600_000),
    .BAUD_RATE   (100_000),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .data_in (data_in),
    .send    (send),
    .tx      (tx),
    .data_out(data_out),
    .valid   (valid),
    .busy    (busy)
  );

  // A received frame: start bit clears valid; a good stop bit with a legal byte sets the symbol
  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    exp_valid = 1'b0;
    if (stop_ok && (b >> 4) == 0 && (b % 4) == 1) begin
      exp_valid = 1'b1;
      exp_dout  = 2'((b / 4) % 4);
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b still set after %0d clocks, required 0", busy, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drv_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    drv_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || data_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b valid=%b data_out=%b, required 1 0 0 00",
               tx, busy, valid, data_out);
    end
    rst_n = 1'b1;
    repeat (1600) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || data_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_hold: tx=%b busy=%b valid=%b data_out=%b, required 1 0 0 00",
               tx, busy, valid, data_out);
    end
  endtask

  task automatic test_loopback_legal();
    logic [7:0] codes [4];
    codes = '{8'h01, 8'h05, 8'h09, 8'h0D};
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      send_byte(codes[i]);
      repeat (4) @(negedge clk);
      exp_valid = 1'b0;
      checks++;
      if (valid !== exp_valid) begin
        errors++;
        $display("FAIL legal_valid_drop[%0d]: valid=%b, required %b", i, valid, exp_valid);
      end
      wait_idle();
      repeat (CPB) @(negedge clk);
      model_frame(codes[i], 1'b1);
      checks++;
      if (valid !== exp_valid || data_out !== exp_dout) begin
        errors++;
        $display("FAIL legal_decode[%0h]: valid=%b data_out=%b, required %b %b",
                 codes[i], valid, data_out, exp_valid, exp_dout);
      end
    end
  endtask

  // Sends b in loopback, records tx each clock, checks length, every bit and the decode
  task automatic test_tx_framing(input logic [7:0] b, input logic inject_send);
    logic samp [0:12*CPB];
    logic exp_bit;
    int   n = 0;
    loop_en = 1'b1;
    wait_idle();
    send_byte(b);
    while (busy === 1'b1 && n < 12 * CPB) begin
      samp[n] = tx;
      if (inject_send && n == 3 * CPB) begin
        data_in = ~b;
        send    = 1'b1;
      end else begin
        send = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    send = 1'b0;
    checks++;
    if (n != 10 * CPB) begin
      errors++;
      $display("FAIL busy_length[%0h]: busy high %0d clocks, required %0d", b, n, 10 * CPB);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      checks++;
      if (samp[k*CPB] !== exp_bit || samp[k*CPB + CPB/2] !== exp_bit ||
          samp[k*CPB + CPB - 1] !== exp_bit) begin
        errors++;
        $display("FAIL tx_bit[%0h][%0d]: tx=%b/%b/%b, required %b", b, k,
                 samp[k*CPB], samp[k*CPB + CPB/2], samp[k*CPB + CPB - 1], exp_bit);
      end
    end
    repeat (CPB) @(negedge clk);
    model_frame(b, 1'b1);
    checks++;
    if (tx !== 1'b1 || valid !== exp_valid || data_out !== exp_dout) begin
      errors++;
      $display("FAIL frame_result[%0h]: tx=%b valid=%b data_out=%b, required 1 %b %b",
               b, tx, valid, data_out, exp_valid, exp_dout);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bytes [2];
    bytes = '{8'h03, 8'h15};
    for (int i = 0; i < 2; i++) begin
      wait_idle();
      send_byte(bytes[i]);
      wait_idle();
      repeat (CPB) @(negedge clk);
      model_frame(bytes[i], 1'b1);
      checks++;
      if (valid !== exp_valid || data_out !== exp_dout) begin
        errors++;
        $display("FAIL illegal[%0h]: valid=%b data_out=%b, required %b %b",
                 bytes[i], valid, data_out, exp_valid, exp_dout);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) b = {4'b0000, 2'($urandom_range(0, 3)), 2'b01};
      else                           b = 8'($urandom);
      test_tx_framing(b, 1'b0);
    end
  endtask

  task automatic test_glitch();
    test_tx_framing(8'h05, 1'b0);
    loop_en = 1'b0;
    @(negedge clk);
    drv_rx = 1'b0;
    @(negedge clk);
    drv_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    exp_valid = 1'b0;
    checks++;
    if (valid !== exp_valid || data_out !== exp_dout) begin
      errors++;
      $display("FAIL rx_glitch: valid=%b data_out=%b, required %b %b",
               valid, data_out, exp_valid, exp_dout);
    end
  endtask

  task automatic test_framing_err();
    test_tx_framing(8'h0D, 1'b0);
    loop_en = 1'b0;
    drive_rx_frame(8'h05, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    model_frame(8'h05, 1'b0);
    checks++;
    if (valid !== exp_valid || data_out !== exp_dout) begin
      errors++;
      $display("FAIL framing_error: valid=%b data_out=%b, required %b %b",
               valid, data_out, exp_valid, exp_dout);
    end
    loop_en = 1'b1;
  endtask

  task automatic test_reset_mid_tx();
    loop_en = 1'b1;
    wait_idle();
    send_byte(8'hA5);
    repeat (4 * CPB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_valid = 1'b0;
    exp_dout  = 2'b00;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || valid !== exp_valid || data_out !== exp_dout) begin
      errors++;
      $display("FAIL reset_mid_tx: tx=%b busy=%b valid=%b data_out=%b, required 1 0 %b %b",
               tx, busy, valid, data_out, exp_valid, exp_dout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_tx_framing(8'h0D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loopback_legal();
    test_tx_framing(8'hA5, 1'b0);
    test_tx_framing(8'h09, 1'b1);
    test_illegal();
    test_random();
    test_glitch();
    test_framing_err();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
